// File: rtl/banked_ram_arb.sv
// ============================================================================
// Module   : banked_ram_arb
// Brief    : Multi-bank, multi-channel RAM with per-bank round-robin arbiters
//            and a fixed 1-cycle read response routed back to each channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_ram_arb #(
    parameter int NUM_BANKS  = 4,
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH-1:0]                     req_valid,
    output logic [NUM_CH-1:0]                     req_ready,
    input  logic [NUM_CH-1:0]                     req_we,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_CH-1:0]                     rsp_valid,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]     rsp_rdata
);

    localparam int BW    = $clog2(NUM_BANKS);
    localparam int BIW   = (BW > 0) ? BW : 1;
    localparam int RW    = ADDR_WIDTH - BW;
    localparam int DEPTH = 1 << RW;
    localparam int CIW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][BIW-1:0]           ch_bank;
    logic [NUM_CH-1:0][RW-1:0]            ch_row;

    logic [NUM_BANKS-1:0][NUM_CH-1:0]     gnt;
    logic [NUM_BANKS-1:0]                 gnt_any;
    logic [NUM_BANKS-1:0][CIW-1:0]        gnt_idx;
    logic [NUM_BANKS-1:0][CIW-1:0]        rr_ptr_q;
    logic [NUM_BANKS-1:0][CIW-1:0]        rr_ptr_d;

    logic [NUM_BANKS-1:0]                 bank_we;
    logic [NUM_BANKS-1:0][RW-1:0]         bank_row;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

    logic [NUM_CH-1:0]                    rsp_valid_q;
    logic [NUM_CH-1:0]                    rsp_valid_d;
    logic [NUM_CH-1:0][BIW-1:0]           rsp_bank_q;
    logic [NUM_CH-1:0][BIW-1:0]           rsp_bank_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    rsp_hold_q;

    // Low-order interleave: bank from the LSBs, row from the remaining bits.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_split
            if (BW > 0) begin : g_multi_bank
                assign ch_bank[c] = req_addr[c][BIW-1:0];
            end else begin : g_single_bank
                assign ch_bank[c] = '0;
            end
            assign ch_row[c] = req_addr[c][ADDR_WIDTH-1:BW];
        end
    endgenerate

    // Round-robin: first pass looks at channels at or above the pointer,
    // second pass wraps around to the channels below it.
    always_comb begin
        gnt     = '0;
        gnt_any = '0;
        gnt_idx = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!gnt_any[b] && req_valid[c] && (ch_bank[c] == BIW'(b)) &&
                    (CIW'(c) >= rr_ptr_q[b])) begin
                    gnt_any[b]    = 1'b1;
                    gnt[b][c]     = 1'b1;
                    gnt_idx[b]    = CIW'(c);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!gnt_any[b] && req_valid[c] && (ch_bank[c] == BIW'(b))) begin
                    gnt_any[b]    = 1'b1;
                    gnt[b][c]     = 1'b1;
                    gnt_idx[b]    = CIW'(c);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                req_ready[c] = req_ready[c] | gnt[b][c];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_any[b]) begin
                rr_ptr_d[b] = (gnt_idx[b] == CIW'(NUM_CH - 1)) ? '0
                                                              : gnt_idx[b] + CIW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Steer the granted channel's request onto each bank's single port.
    always_comb begin
        bank_we    = '0;
        bank_row   = '0;
        bank_wdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt[b][c]) begin
                    bank_we[b]    = req_we[c];
                    bank_row[b]   = ch_row[c];
                    bank_wdata[b] = req_wdata[c];
                end
            end
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (gnt_any[b]) begin
                    if (bank_we[b]) begin
                        mem[bank_row[b]] <= bank_wdata[b];
                    end else begin
                        rdata_q <= mem[bank_row[b]];
                    end
                end
            end

            assign bank_rdata[b] = rdata_q;
        end
    endgenerate

    always_comb begin
        rsp_valid_d = '0;
        rsp_bank_d  = rsp_bank_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_valid[c] && req_ready[c] && !req_we[c]) begin
                rsp_valid_d[c] = 1'b1;
                rsp_bank_d[c]  = ch_bank[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_bank_q  <= '0;
            rsp_hold_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_bank_q  <= rsp_bank_d;
            rsp_hold_q  <= rsp_rdata;
        end
    end

    // Live bank data while the response is valid, otherwise the last value.
    always_comb begin
        rsp_rdata = rsp_hold_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rsp_valid_q[c]) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (rsp_bank_q[c] == BIW'(b)) begin
                        rsp_rdata[c] = bank_rdata[b];
                    end
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_banked_ram_arb.sv
// ============================================================================
// Module   : tb_banked_ram_arb
// Brief    : Directed self-checking bench for banked_ram_arb (4 banks, 2 ch).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_ram_arb;

    localparam int NB = 4;
    localparam int NC = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NC-1:0]           req_valid = '0;
    logic [NC-1:0]           req_ready;
    logic [NC-1:0]           req_we = '0;
    logic [NC-1:0][AW-1:0]   req_addr = '0;
    logic [NC-1:0][DW-1:0]   req_wdata = '0;
    logic [NC-1:0]           rsp_valid;
    logic [NC-1:0][DW-1:0]   rsp_rdata;

    int checks = 0;
    int passed = 0;

    banked_ram_arb #(
        .NUM_BANKS (NB),
        .NUM_CH    (NC),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic drive(input int ch, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        req_valid[ch] = 1'b1;
        req_we[ch]    = we;
        req_addr[ch]  = addr;
        req_wdata[ch] = data;
    endtask

    // Presents an uncontended write; it is committed by the following edge.
    task automatic wr(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        cyc();
        idle_all();
        drive(ch, 1'b1, addr, data);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); else passed++;
        checks++; if (rsp_rdata !== '0) $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); else passed++;
        checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", req_ready); else passed++;
        #10 rst = 1'b0;
        cyc();
        #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL idle_ready: got %b expected 00", req_ready); else passed++;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL idle_rsp_valid: got %b expected 00", rsp_valid); else passed++;
    endtask

    task automatic test_single();
        cyc(); idle_all(); drive(0, 1'b1, 10'h005, 32'hDEADBEEF); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL single_wr_ready: got %b expected 01", req_ready); else passed++;
        cyc(); idle_all(); drive(0, 1'b0, 10'h005, '0); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL single_rd_ready: got %b expected 01", req_ready); else passed++;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL single_wr_no_rsp: got %b expected 00", rsp_valid); else passed++;
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h expected deadbeef", rsp_rdata[0]); else passed++;
        cyc(); #1;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL single_rsp_once: got %b expected 00", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== 32'hDEADBEEF) $display("FAIL single_rdata_hold: got %h expected deadbeef", rsp_rdata[0]); else passed++;
    endtask

    task automatic test_parallel();
        wr(0, 10'h004, 32'h11110004);
        wr(0, 10'h001, 32'h22220001);
        cyc(); idle_all(); drive(0, 1'b0, 10'h004, '0); drive(1, 1'b0, 10'h001, '0); #1;
        checks++; if (req_ready !== 2'b11) $display("FAIL par_ready: got %b expected 11", req_ready); else passed++;
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b11) $display("FAIL par_rsp_valid: got %b expected 11", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== 32'h11110004) $display("FAIL par_rdata0: got %h expected 11110004", rsp_rdata[0]); else passed++;
        checks++; if (rsp_rdata[1] !== 32'h22220001) $display("FAIL par_rdata1: got %h expected 22220001", rsp_rdata[1]); else passed++;
    endtask

    task automatic test_conflict_rr();
        logic [NC-1:0] exp_g;
        logic [NC-1:0] prev_g;
        int n0 = 0;
        int n1 = 0;
        // Written by ch1 so bank 2's pointer lands back on ch0.
        wr(1, 10'h002, 32'hC0DE0002);
        wr(1, 10'h006, 32'hC0DE0006);
        prev_g = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(); idle_all(); drive(0, 1'b0, 10'h002, '0); drive(1, 1'b0, 10'h006, '0); #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== exp_g) $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_g); else passed++;
            if (k > 0) begin
                checks++; if (rsp_valid !== prev_g) $display("FAIL rr_rsp%0d: got %b expected %b", k, rsp_valid, prev_g); else passed++;
                if (prev_g[0]) begin
                    checks++; if (rsp_rdata[0] !== 32'hC0DE0002) $display("FAIL rr_rdata%0d: got %h expected c0de0002", k, rsp_rdata[0]); else passed++;
                end else begin
                    checks++; if (rsp_rdata[1] !== 32'hC0DE0006) $display("FAIL rr_rdata%0d: got %h expected c0de0006", k, rsp_rdata[1]); else passed++;
                end
            end
            if (rsp_valid[0]) n0++;
            if (rsp_valid[1]) n1++;
            prev_g = exp_g;
        end
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b10) $display("FAIL rr_rsp_last: got %b expected 10", rsp_valid); else passed++;
        checks++; if (rsp_rdata[1] !== 32'hC0DE0006) $display("FAIL rr_rdata_last: got %h expected c0de0006", rsp_rdata[1]); else passed++;
        if (rsp_valid[0]) n0++;
        if (rsp_valid[1]) n1++;
        checks++; if (n0 != 2 || n1 != 2) $display("FAIL rr_rsp_count: got %0d/%0d expected 2/2", n0, n1); else passed++;
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            wr(0, AW'(i), 32'hF00D0000 | i);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(); idle_all(); drive(0, 1'b0, AW'(i), '0); #1;
            checks++; if (req_ready[0] !== 1'b1) $display("FAIL stream_ready%0d: got %b expected 1", i, req_ready[0]); else passed++;
            if (i > 0) begin
                checks++; if (rsp_valid[0] !== 1'b1) $display("FAIL stream_valid%0d: got %b expected 1", i, rsp_valid[0]); else passed++;
                checks++; if (rsp_rdata[0] !== (32'hF00D0000 | (i - 1))) $display("FAIL stream_rdata%0d: got %h expected %h", i, rsp_rdata[0], 32'hF00D0000 | (i - 1)); else passed++;
            end
        end
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid[0] !== 1'b1) $display("FAIL stream_valid16: got %b expected 1", rsp_valid[0]); else passed++;
        checks++; if (rsp_rdata[0] !== 32'hF00D000F) $display("FAIL stream_rdata16: got %h expected f00d000f", rsp_rdata[0]); else passed++;
    endtask

    task automatic test_boundary();
        wr(0, 10'h3FF, 32'hA5A5A5A5);
        cyc(); idle_all(); drive(0, 1'b0, 10'h3FF, '0); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL bnd_ready: got %b expected 01", req_ready); else passed++;
        cyc(); idle_all(); drive(0, 1'b0, 10'h000, '0); #1;
        checks++; if (rsp_valid !== 2'b01) $display("FAIL bnd_valid: got %b expected 01", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== 32'hA5A5A5A5) $display("FAIL bnd_rdata: got %h expected a5a5a5a5", rsp_rdata[0]); else passed++;
        // 0x3FF and 0x007 share bank 3; bank 3's pointer currently favours ch1.
        cyc(); idle_all(); drive(0, 1'b0, 10'h3FF, '0); drive(1, 1'b0, 10'h007, '0); #1;
        checks++; if (rsp_rdata[0] !== 32'hF00D0000) $display("FAIL bnd_addr0: got %h expected f00d0000", rsp_rdata[0]); else passed++;
        checks++; if (req_ready !== 2'b10) $display("FAIL bnd_bank3_conflict: got %b expected 10", req_ready); else passed++;
        cyc(); idle_all(); drive(0, 1'b0, 10'h3FF, '0); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL bnd_held_grant: got %b expected 01", req_ready); else passed++;
        checks++; if (rsp_valid !== 2'b10) $display("FAIL bnd_ch1_valid: got %b expected 10", rsp_valid); else passed++;
        checks++; if (rsp_rdata[1] !== 32'hF00D0007) $display("FAIL bnd_ch1_rdata: got %h expected f00d0007", rsp_rdata[1]); else passed++;
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b01) $display("FAIL bnd_ch0_valid: got %b expected 01", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== 32'hA5A5A5A5) $display("FAIL bnd_ch0_rdata: got %h expected a5a5a5a5", rsp_rdata[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        wr(0, 10'h00A, 32'h0BAD000A);
        cyc(); idle_all(); drive(0, 1'b0, 10'h003, '0); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL rstm_ready: got %b expected 01", req_ready); else passed++;
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b01) $display("FAIL rstm_valid_pre: got %b expected 01", rsp_valid); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL rstm_async_drop: got %b expected 00", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== '0) $display("FAIL rstm_rdata_clr: got %h expected 0", rsp_rdata[0]); else passed++;
        cyc(); #1 rst = 1'b0;
        cyc(); idle_all(); drive(0, 1'b0, 10'h003, '0); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL rstm_ready2: got %b expected 01", req_ready); else passed++;
        #6 rst = 1'b1;
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL rstm_no_rsp: got %b expected 00", rsp_valid); else passed++;
        rst = 1'b0;
        cyc(); #1;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL rstm_stays0: got %b expected 00", rsp_valid); else passed++;
        cyc(); idle_all(); drive(0, 1'b0, 10'h002, '0); drive(1, 1'b0, 10'h00A, '0); #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL rstm_first_ch0: got %b expected 01", req_ready); else passed++;
        cyc(); idle_all(); drive(1, 1'b0, 10'h00A, '0); #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL rstm_then_ch1: got %b expected 10", req_ready); else passed++;
        checks++; if (rsp_valid !== 2'b01) $display("FAIL rstm_rsp0_valid: got %b expected 01", rsp_valid); else passed++;
        checks++; if (rsp_rdata[0] !== 32'hF00D0002) $display("FAIL rstm_rsp0_rdata: got %h expected f00d0002", rsp_rdata[0]); else passed++;
        cyc(); idle_all(); #1;
        checks++; if (rsp_valid !== 2'b10) $display("FAIL rstm_rsp1_valid: got %b expected 10", rsp_valid); else passed++;
        checks++; if (rsp_rdata[1] !== 32'h0BAD000A) $display("FAIL rstm_rsp1_rdata: got %h expected 0bad000a", rsp_rdata[1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parallel();
        test_conflict_rr();
        test_streaming();
        test_boundary();
        test_reset_mid();
        cyc();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
